instr_cache: RTL and testbench
==============================

# instr_cache

Direct-mapped instruction cache sitting between the program counter and instruction memory in the fetch stage. It answers every fetch address in the same cycle on a hit, and on a miss holds the fetch stage by asserting a stall that drives the program counter's `StallF`. Meanwhile it refills the missing line from memory over a request/acknowledge handshake followed by a burst of data beats.

## Interface
- `WORD_SIZE`, 32 — instruction and address width in bits.
- `NUM_LINES`, 4 — number of cache lines; power of two, at least 2.
- `WORDS_PER_LINE`, 4 — words per line; power of two, at least 2.

- `clk`  in  1  — single clock; all state changes on its rising edge.
- `rst`  in  1  — reset, synchronous, active-low (asserted when 0).
- `PC`  in  WORD_SIZE  — fetch byte address; bits [1:0] are ignored.
- `Instr`  out  WORD_SIZE  — fetched instruction, valid when `IMissStall`=0.
- `IMissStall`  out  1  — fetch must hold; connects to the PC `StallF`.
- `Invalidate`  in  1  — clear all valid bits.
- `MemReq`  out  1  — line-fill request.
- `MemAddr`  out  WORD_SIZE  — line-aligned byte address of the fill.
- `MemAck`  in  1  — memory accepted the request.
- `MemDataValid`  in  1  — `MemData` carries one fill beat this cycle.
- `MemData`  in  WORD_SIZE  — fill data, one word per beat, ascending word order.

## Operation
- Address split, with OFF = log2(WORDS_PER_LINE) and IDX = log2(NUM_LINES):
  - word offset = `PC[OFF+1:2]`
  - index = `PC[OFF+IDX+1:OFF+2]`
  - tag = the remaining upper bits.
- Storage:
  - valid bit per line, reset to 0;
  - tag array and data array, not reset.
- Hit means `valid[index]` and the stored tag equals the tag of `PC`. Lookup is combinational.
- `Instr` is the data word on a hit, and 0 otherwise.
- `IMissStall` = !hit while in IDLE, and 1 in REQ and FILL.
- FSM states: IDLE, REQ, FILL.
  - **IDLE:** on a miss, latch the line address (`PC` with offset and byte bits zeroed) into `MemAddr`, clear the beat counter, and go to REQ.
  - **REQ:** `MemReq`=1 and `MemAddr` held stable. When `MemAck`=1 is sampled, go to FILL; `MemReq` drops in the next cycle.
  - **FILL:** each cycle with `MemDataValid`=1, write `MemData` to word [beat counter] of the latched line and increment the counter. On the beat where the counter equals WORDS_PER_LINE-1, write the tag, set valid, and go to IDLE.
- `MemDataValid` is ignored in IDLE and REQ.
- A changing `PC` during REQ or FILL does not affect the fill. Lookup resumes against the current `PC` in IDLE; a new miss starts a new fill.
- `Invalidate`=1 clears all valid bits at the next edge in any state. A fill in progress still completes, but if `Invalidate` coincides with the final beat, that line is left invalid (invalidate wins).
- Reset state:
  - state IDLE, `MemReq`=0, `MemAddr`=0, beat counter 0, all valid bits 0.
  - While `rst`=0, `IMissStall` is forced to 1 and `Instr` to 0.
  - Reset during REQ or FILL abandons the fill with no line made valid; beats arriving after reset are ignored.

## Timing
- Hit: 0-cycle latency, with `Instr` and `IMissStall`=0 in the same cycle as `PC`.
- Miss detected in cycle t:
  - `MemReq`=1 from t+1.
  - If `MemAck` is high in cycle a, FILL runs from a+1.
  - If the last beat arrives in cycle b, IDLE with valid line at b+1; `IMissStall`=0 and correct `Instr` in b+1.
- Minimum miss penalty with default parameters (ack in t+1, beats t+2..t+5): `IMissStall` high for t..t+5, a hit in t+6.
- `MemAddr` changes only on the IDLE→REQ transition.
- Gaps between beats (`MemDataValid`=0) simply stall FILL; there is no timeout.

## Test plan
- Cold miss: release reset, `PC`=0x100, memory acks immediately and returns 0xA0..0xA3 back-to-back.
  - `MemReq` high in cycle 1 with `MemAddr`=0x100.
  - `IMissStall` high cycles 0–5; cycle 6 gives `Instr`=0xA0.
  - Then `PC`=0x104/0x108/0x10C gives 0xA1/0xA2/0xA3 with no stall.
- Conflict: after the above, `PC`=0x140 (same index, different tag) misses and refills. Returning to `PC`=0x100 misses again.
- Slow memory:
  - `MemAck` delayed 3 cycles: `MemReq` and `MemAddr` held stable throughout.
  - Beats with one-cycle gaps: fill completes only after the 4th valid beat, with words in order.
- `PC` redirect mid-fill: `PC` changes to 0x200 during FILL. Fill of 0x100 completes, then 0x200 misses and a second request is issued with `MemAddr`=0x200.
- Invalidate:
  - Asserted in IDLE after fill: the next access to 0x100 misses.
  - Asserted on the final beat of a fill: that line stays invalid.
- Reset mid-FILL after 2 beats:
  - Returns to IDLE with `MemReq`=0.
  - Stray `MemDataValid` beats are ignored.
  - Access to the same line misses and refills cleanly.

Source files
------------

// File: rtl/instr_cache.sv
// Direct-mapped instruction cache for the fetch stage: a hit returns data in the same cycle,
// and a miss stalls fetch while the line is refilled over a req/ack handshake and a data burst.
module instr_cache #(
   parameter int unsigned WORD_SIZE      = 32,
   parameter int unsigned NUM_LINES      = 4,
   parameter int unsigned WORDS_PER_LINE = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WORD_SIZE-1:0] PC,
   output logic [WORD_SIZE-1:0] Instr,
   output logic                 IMissStall,
   input  logic                 Invalidate,
   output logic                 MemReq,
   output logic [WORD_SIZE-1:0] MemAddr,
   input  logic                 MemAck,
   input  logic                 MemDataValid,
   input  logic [WORD_SIZE-1:0] MemData
);

   localparam int unsigned OFF     = $clog2(WORDS_PER_LINE);
   localparam int unsigned IDX     = $clog2(NUM_LINES);
   localparam int unsigned TAG_LSB = OFF + IDX + 2;
   localparam int unsigned TAG_W   = WORD_SIZE - TAG_LSB;
   localparam int unsigned DEPTH   = NUM_LINES * WORDS_PER_LINE;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL} state_e;

   state_e                 state_q, state_d;
   logic                   mem_req_q, mem_req_d;
   logic [WORD_SIZE-1:0]   mem_addr_q, mem_addr_d;
   logic [OFF-1:0]         beat_q, beat_d;
   logic [NUM_LINES-1:0]   valid_q, valid_d;

   // Storage arrays are deliberately left unreset; the valid bits guard them.
   logic [TAG_W-1:0]       tag_q  [NUM_LINES];
   logic [WORD_SIZE-1:0]   data_q [DEPTH];
   logic                   data_we;
   logic                   tag_we;

   logic [OFF-1:0]         pc_off;
   logic [IDX-1:0]         pc_idx;
   logic [TAG_W-1:0]       pc_tag;
   logic [IDX-1:0]         fill_idx;
   logic [TAG_W-1:0]       fill_tag;
   logic                   hit_c;

   // Byte-select bits of the fetch address play no role in a word-addressed cache.
   logic                   unused_pc;
   assign unused_pc = &{1'b0, PC[1:0]};

   assign pc_off   = PC[OFF+1:2];
   assign pc_idx   = PC[OFF+IDX+1:OFF+2];
   assign pc_tag   = PC[WORD_SIZE-1:TAG_LSB];
   assign fill_idx = mem_addr_q[OFF+IDX+1:OFF+2];
   assign fill_tag = mem_addr_q[WORD_SIZE-1:TAG_LSB];

   // Combinational lookup against the current fetch address.
   assign hit_c      = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
   assign Instr      = (rst && hit_c) ? data_q[{pc_idx, pc_off}] : '0;
   assign IMissStall = !rst || (state_q != S_IDLE) || !hit_c;
   assign MemReq     = mem_req_q;
   assign MemAddr    = mem_addr_q;

   // Next-state logic for the refill FSM and the valid bits.
   always_comb begin
      state_d    = state_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      beat_d     = beat_q;
      valid_d    = valid_q;
      data_we    = 1'b0;
      tag_we     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (!hit_c) begin
               state_d    = S_REQ;
               mem_req_d  = 1'b1;
               mem_addr_d = {pc_tag, pc_idx, {(OFF + 2){1'b0}}};
               beat_d     = '0;
            end
         end
         S_REQ: begin
            if (MemAck) begin
               state_d   = S_FILL;
               mem_req_d = 1'b0;
            end
         end
         S_FILL: begin
            if (MemDataValid) begin
               data_we = 1'b1;
               beat_d  = beat_q + OFF'(1);
               if (beat_q == OFF'(WORDS_PER_LINE - 1)) begin
                  tag_we            = 1'b1;
                  valid_d[fill_idx] = 1'b1;
                  state_d           = S_IDLE;
               end
            end
         end
         default: begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
         end
      endcase

      // Invalidate overrides a line completing on the same edge.
      if (Invalidate) begin
         valid_d = '0;
      end
   end

   // Control state registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         beat_q     <= '0;
         valid_q    <= '0;
      end else begin
         state_q    <= state_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         beat_q     <= beat_d;
         valid_q    <= valid_d;
      end
   end

   // Tag and data array writes during a line fill; blocked while in reset.
   always_ff @(posedge clk) begin
      if (rst && data_we) begin
         data_q[{fill_idx, beat_q}] <= MemData;
      end
      if (rst && tag_we) begin
         tag_q[fill_idx] <= fill_tag;
      end
   end

endmodule

// File: tb/tb_instr_cache.sv
// Directed bench for instr_cache: a vector table for cold miss, hits and conflict refill,
// followed by hand-written sequences for slow memory, redirect, invalidate and mid-fill reset.
module tb_instr_cache;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   typedef struct packed {
      logic        rst_n;
      logic [31:0] pc;
      logic        inv;
      logic        ack;
      logic        dv;
      logic [31:0] data;
      logic        st;
      logic        ck_ra;
      logic        rq;
      logic [31:0] ad;
      logic        ck_ins;
      logic [31:0] ins;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] PC;
   logic [31:0] Instr;
   logic        IMissStall;
   logic        Invalidate;
   logic        MemReq;
   logic [31:0] MemAddr;
   logic        MemAck;
   logic        MemDataValid;
   logic [31:0] MemData;

   int n_tests = 0;
   int n_fail  = 0;

   vec_t tbl [0:26];

   always #5 clk = ~clk;

   instr_cache #(.WORD_SIZE(32), .NUM_LINES(4), .WORDS_PER_LINE(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .PC           (PC),
      .Instr        (Instr),
      .IMissStall   (IMissStall),
      .Invalidate   (Invalidate),
      .MemReq       (MemReq),
      .MemAddr      (MemAddr),
      .MemAck       (MemAck),
      .MemDataValid (MemDataValid),
      .MemData      (MemData)
   );

   function automatic vec_t mk(input logic r, input logic [31:0] pc, input logic inv,
                               input logic ack, input logic dv, input logic [31:0] d,
                               input logic st, input logic ck_ra, input logic rq,
                               input logic [31:0] ad, input logic ck_ins, input logic [31:0] ins);
      vec_t v;
      v.rst_n = r;  v.pc = pc;   v.inv = inv; v.ack = ack; v.dv = dv; v.data = d;
      v.st = st;    v.ck_ra = ck_ra; v.rq = rq; v.ad = ad; v.ck_ins = ck_ins; v.ins = ins;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Drive one cycle of inputs just after the edge, check outputs at the falling edge.
   task automatic apply(input string nm, input vec_t v);
      rst          = v.rst_n;
      PC           = v.pc;
      Invalidate   = v.inv;
      MemAck       = v.ack;
      MemDataValid = v.dv;
      MemData      = v.data;
      @(negedge clk);
      chk({nm, ".stall"}, 32'(IMissStall), 32'(v.st));
      if (v.ck_ra) begin
         chk({nm, ".req"},  32'(MemReq), 32'(v.rq));
         chk({nm, ".addr"}, MemAddr, v.ad);
      end
      if (v.ck_ins) begin
         chk({nm, ".instr"}, Instr, v.ins);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Cold miss on 0x100, sequential hits, conflict with 0x140, return to 0x100.
      tbl[0]  = mk(L, 32'h100, L, L, L, 32'h0,  H, H, L, 32'h0,   H, 32'h0);
      tbl[1]  = mk(L, 32'h100, L, L, L, 32'h0,  H, H, L, 32'h0,   H, 32'h0);
      tbl[2]  = mk(H, 32'h100, L, L, L, 32'h0,  H, H, L, 32'h0,   H, 32'h0);
      tbl[3]  = mk(H, 32'h100, L, H, L, 32'h0,  H, H, H, 32'h100, H, 32'h0);
      tbl[4]  = mk(H, 32'h100, L, L, H, 32'hA0, H, H, L, 32'h100, H, 32'h0);
      tbl[5]  = mk(H, 32'h100, L, L, H, 32'hA1, H, H, L, 32'h100, H, 32'h0);
      tbl[6]  = mk(H, 32'h100, L, L, H, 32'hA2, H, H, L, 32'h100, H, 32'h0);
      tbl[7]  = mk(H, 32'h100, L, L, H, 32'hA3, H, H, L, 32'h100, H, 32'h0);
      tbl[8]  = mk(H, 32'h100, L, L, L, 32'h0,  L, H, L, 32'h100, H, 32'hA0);
      tbl[9]  = mk(H, 32'h104, L, L, L, 32'h0,  L, H, L, 32'h100, H, 32'hA1);
      tbl[10] = mk(H, 32'h108, L, L, L, 32'h0,  L, H, L, 32'h100, H, 32'hA2);
      tbl[11] = mk(H, 32'h10C, L, L, L, 32'h0,  L, H, L, 32'h100, H, 32'hA3);
      tbl[12] = mk(H, 32'h140, L, L, L, 32'h0,  H, H, L, 32'h100, H, 32'h0);
      tbl[13] = mk(H, 32'h140, L, H, L, 32'h0,  H, H, H, 32'h140, H, 32'h0);
      tbl[14] = mk(H, 32'h140, L, L, H, 32'hB0, H, H, L, 32'h140, H, 32'h0);
      tbl[15] = mk(H, 32'h140, L, L, H, 32'hB1, H, H, L, 32'h140, H, 32'h0);
      tbl[16] = mk(H, 32'h140, L, L, H, 32'hB2, H, H, L, 32'h140, H, 32'h0);
      tbl[17] = mk(H, 32'h140, L, L, H, 32'hB3, H, H, L, 32'h140, H, 32'h0);
      tbl[18] = mk(H, 32'h140, L, L, L, 32'h0,  L, H, L, 32'h140, H, 32'hB0);
      tbl[19] = mk(H, 32'h14C, L, L, L, 32'h0,  L, H, L, 32'h140, H, 32'hB3);
      tbl[20] = mk(H, 32'h100, L, L, L, 32'h0,  H, H, L, 32'h140, H, 32'h0);
      tbl[21] = mk(H, 32'h100, L, H, L, 32'h0,  H, H, H, 32'h100, H, 32'h0);
      tbl[22] = mk(H, 32'h100, L, L, H, 32'hC0, H, H, L, 32'h100, H, 32'h0);
      tbl[23] = mk(H, 32'h100, L, L, H, 32'hC1, H, H, L, 32'h100, H, 32'h0);
      tbl[24] = mk(H, 32'h100, L, L, H, 32'hC2, H, H, L, 32'h100, H, 32'h0);
      tbl[25] = mk(H, 32'h100, L, L, H, 32'hC3, H, H, L, 32'h100, H, 32'h0);
      tbl[26] = mk(H, 32'h108, L, L, L, 32'h0,  L, H, L, 32'h100, H, 32'hC2);

      rst = 1'b0; PC = 32'h0; Invalidate = 1'b0; MemAck = 1'b0;
      MemDataValid = 1'b0; MemData = 32'h0;
      @(posedge clk); #1;
      @(posedge clk); #1;

      for (int i = 0; i < 27; i++) begin
         apply($sformatf("cold[%0d]", i), tbl[i]);
      end

      // Slow memory: ack after three extra REQ cycles, beats separated by gaps.
      apply("slow.miss", mk(H, 32'h180, L, L, L, 32'h0, H, H, L, 32'h100, H, 32'h0));
      for (int i = 0; i < 3; i++) begin
         apply($sformatf("slow.wait%0d", i), mk(H, 32'h180, L, L, L, 32'h0, H, H, H, 32'h180, H, 32'h0));
      end
      apply("slow.ack", mk(H, 32'h180, L, H, L, 32'h0, H, H, H, 32'h180, H, 32'h0));
      for (int i = 0; i < 7; i++) begin
         logic [31:0] d;
         d = 32'hD0 + 32'(i / 2);
         apply($sformatf("slow.beat%0d", i),
               mk(H, 32'h180, L, L, ((i % 2) == 0) ? H : L, d, H, H, L, 32'h180, H, 32'h0));
      end
      for (int i = 0; i < 4; i++) begin
         apply($sformatf("slow.hit%0d", i),
               mk(H, 32'h180 + 32'(4 * i), L, L, L, 32'h0, L, H, L, 32'h180, H, 32'hD0 + 32'(i)));
      end

      // PC redirect to 0x200 in the middle of the 0x100 fill.
      apply("redir.miss", mk(H, 32'h100, L, L, L, 32'h0,  H, H, L, 32'h180, H, 32'h0));
      apply("redir.ack",  mk(H, 32'h100, L, H, L, 32'h0,  H, H, H, 32'h100, H, 32'h0));
      apply("redir.b0",   mk(H, 32'h100, L, L, H, 32'hE0, H, H, L, 32'h100, H, 32'h0));
      apply("redir.b1",   mk(H, 32'h200, L, L, H, 32'hE1, H, H, L, 32'h100, H, 32'h0));
      apply("redir.b2",   mk(H, 32'h200, L, L, H, 32'hE2, H, H, L, 32'h100, H, 32'h0));
      apply("redir.b3",   mk(H, 32'h200, L, L, H, 32'hE3, H, H, L, 32'h100, H, 32'h0));
      apply("redir.miss2", mk(H, 32'h200, L, L, L, 32'h0, H, H, L, 32'h100, H, 32'h0));
      apply("redir.req2", mk(H, 32'h200, L, H, L, 32'h0,  H, H, H, 32'h200, H, 32'h0));
      for (int i = 0; i < 4; i++) begin
         apply($sformatf("redir.f%0d", i), mk(H, 32'h200, L, L, H, 32'hF0 + 32'(i), H, H, L, 32'h200, H, 32'h0));
      end
      apply("redir.hit",  mk(H, 32'h204, L, L, L, 32'h0,  L, H, L, 32'h200, H, 32'hF1));

      // Invalidate in IDLE, then invalidate coinciding with the final fill beat.
      apply("inv.idle",   mk(H, 32'h200, H, L, L, 32'h0,  L, H, L, 32'h200, H, 32'hF0));
      apply("inv.miss",   mk(H, 32'h200, L, L, L, 32'h0,  H, H, L, 32'h200, H, 32'h0));
      apply("inv.ack",    mk(H, 32'h200, L, H, L, 32'h0,  H, H, H, 32'h200, H, 32'h0));
      apply("inv.g0",     mk(H, 32'h200, L, L, H, 32'h60, H, H, L, 32'h200, H, 32'h0));
      apply("inv.g1",     mk(H, 32'h200, L, L, H, 32'h61, H, H, L, 32'h200, H, 32'h0));
      apply("inv.g2",     mk(H, 32'h200, L, L, H, 32'h62, H, H, L, 32'h200, H, 32'h0));
      apply("inv.g3",     mk(H, 32'h200, H, L, H, 32'h63, H, H, L, 32'h200, H, 32'h0));
      apply("inv.last",   mk(H, 32'h200, L, L, L, 32'h0,  H, H, L, 32'h200, H, 32'h0));
      apply("inv.req",    mk(H, 32'h20C, L, H, L, 32'h0,  H, H, H, 32'h200, H, 32'h0));
      for (int i = 0; i < 4; i++) begin
         apply($sformatf("inv.h%0d", i), mk(H, 32'h200, L, L, H, 32'h70 + 32'(i), H, H, L, 32'h200, H, 32'h0));
      end
      apply("inv.hit",    mk(H, 32'h20C, L, L, L, 32'h0,  L, H, L, 32'h200, H, 32'h73));

      // Reset after two beats of a fill; stray beats afterwards must be ignored.
      apply("rst.miss",   mk(H, 32'h300, L, L, L, 32'h0,    H, H, L, 32'h200, H, 32'h0));
      apply("rst.stray0", mk(H, 32'h300, L, L, H, 32'hDEAD, H, H, H, 32'h300, H, 32'h0));
      apply("rst.ack",    mk(H, 32'h300, L, H, L, 32'h0,    H, H, H, 32'h300, H, 32'h0));
      apply("rst.k0",     mk(H, 32'h300, L, L, H, 32'h80,   H, H, L, 32'h300, H, 32'h0));
      apply("rst.k1",     mk(H, 32'h300, L, L, H, 32'h81,   H, H, L, 32'h300, H, 32'h0));
      apply("rst.assert", mk(L, 32'h20C, L, L, H, 32'h82,   H, H, L, 32'h300, H, 32'h0));
      apply("rst.idle",   mk(H, 32'h300, L, L, H, 32'h83,   H, H, L, 32'h0,   H, 32'h0));
      apply("rst.req",    mk(H, 32'h300, L, L, H, 32'hBEEF, H, H, H, 32'h300, H, 32'h0));
      apply("rst.ack2",   mk(H, 32'h300, L, H, L, 32'h0,    H, H, H, 32'h300, H, 32'h0));
      for (int i = 0; i < 4; i++) begin
         apply($sformatf("rst.m%0d", i), mk(H, 32'h300, L, L, H, 32'h90 + 32'(i), H, H, L, 32'h300, H, 32'h0));
      end
      apply("rst.hit1",   mk(H, 32'h304, L, L, L, 32'h0,    L, H, L, 32'h300, H, 32'h91));
      apply("rst.hit3",   mk(H, 32'h30C, L, L, L, 32'h0,    L, H, L, 32'h300, H, 32'h93));
      apply("rst.evict",  mk(H, 32'h20C, L, L, L, 32'h0,    H, H, L, 32'h300, H, 32'h0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
